// File: rtl/hazard_forward_unit_if.sv
// Decode/EX hazard bus between the core datapath (master) and the hazard unit (slave).
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              valid_d_i;
  logic [REG_AW-1:0] rs1_d_i;
  logic [REG_AW-1:0] rs2_d_i;
  logic [REG_AW-1:0] rd_d_i;
  logic              regwrite_d_i;
  logic              memread_d_i;
  logic              pcsrc_e_i;
  logic [1:0]        fwd_a_e_o;
  logic [1:0]        fwd_b_e_o;
  logic              stall_f_o;
  logic              stall_d_o;
  logic              flush_d_o;
  logic              flush_e_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output valid_d_i, rs1_d_i, rs2_d_i, rd_d_i, regwrite_d_i, memread_d_i, pcsrc_e_i,
    input  fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o
  );

  modport slave (
    input  valid_d_i, rs1_d_i, rs2_d_i, rd_d_i, regwrite_d_i, memread_d_i, pcsrc_e_i,
    output fwd_a_e_o, fwd_b_e_o, stall_f_o, stall_d_o, flush_d_o, flush_e_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch flush and EX operand forwarding control for the 5-stage core.
// Tracks its own E/M/W shadow of destination/control bits; stall cycles are counted.
module hazard_forward_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_we,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_we,
  output logic [1:0]        sel
);
  // MEM holds the youngest producer, so it is tested first; x0 never forwards
  always_comb begin
    sel = 2'b00;
    if (m_we && (m_rd != '0) && (m_rd == src))
      sel = 2'b10;
    else if (w_we && (w_rd != '0) && (w_rd == src))
      sel = 2'b01;
  end
endmodule

module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_forward_unit_if.slave hz
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } e_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } mw_t;

  e_t               e_q;
  mw_t              m_q, w_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             lw_hz, lw_stall, flush_e;

  logic [NUM_OPS-1:0][REG_AW-1:0] src_e;
  logic [NUM_OPS-1:0][1:0]        sel_e;

  assign lw_hz    = hz.valid_d_i & e_q.memread & (e_q.rd != '0) &
                    ((e_q.rd == hz.rs1_d_i) | (e_q.rd == hz.rs2_d_i));
  // a taken branch discards the decode instruction, so no point stalling it
  assign lw_stall = lw_hz & ~hz.pcsrc_e_i;
  assign flush_e  = lw_stall | hz.pcsrc_e_i;

  assign hz.stall_f_o   = lw_stall;
  assign hz.stall_d_o   = lw_stall;
  assign hz.flush_d_o   = hz.pcsrc_e_i;
  assign hz.flush_e_o   = flush_e;
  assign hz.stall_cnt_o = stall_cnt;

  assign src_e = {e_q.rs2, e_q.rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_forward_sel #(.REG_AW(REG_AW)) u_sel (
      .src  (src_e[g]),
      .m_rd (m_q.rd),
      .m_we (m_q.regwrite),
      .w_rd (w_q.rd),
      .w_we (w_q.regwrite),
      .sel  (sel_e[g])
    );
  end

  assign hz.fwd_a_e_o = sel_e[0];
  assign hz.fwd_b_e_o = sel_e[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_e) begin
        e_q <= '0;
      end else begin
        e_q.rs1      <= hz.rs1_d_i;
        e_q.rs2      <= hz.rs2_d_i;
        e_q.rd       <= hz.rd_d_i;
        e_q.regwrite <= hz.valid_d_i & hz.regwrite_d_i;
        e_q.memread  <= hz.valid_d_i & hz.memread_d_i;
      end
      m_q.rd       <= e_q.rd;
      m_q.regwrite <= e_q.regwrite;
      w_q          <= m_q;
      if (lw_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule
